// File: rtl/af_sequencer.sv
// af_sequencer
//   Command-driven controller for the activation-function path of the tile array.
//   Compute commands are buffered in a small FIFO. Each one is issued to the array as an
//   instruction plus a one-cycle start pulse. The controller then steers the AF mux and the
//   tanh source, waits for the selected sigmoid/tanh array to report ready, and strobes the
//   NORTH-side write-back. Only one command owns the shared sigmoid/tanh arrays at a time.
//
// Optional feature (compile-time macro AF_TIMEOUT_EN):
//   When AF_TIMEOUT_EN is defined, a watchdog bounds WAIT_EXEC and AF_WAIT to TIMEOUT_CYCLES.
//   On expiry the command is dropped without cmd_done, err pulses and the FSM returns to IDLE.
//   Without the macro both wait states wait indefinitely.
//
// Ports
//   clk                  in   rising-edge clock
//   reset                in   asynchronous reset, active low (0 = reset)
//   cmd_valid            in   command push request
//   cmd_ready            out  FIFO not full
//   cmd_instr            in   32-bit instruction for the array
//   cmd_af               in   0=pass-through, 1=sigmoid, 2=tanh, 3=illegal
//   cmd_tanh_src         in   0=EAST, 1=NORTH tanh source
//   top_start            out  one-cycle start pulse to the array
//   top_instruction      out  instruction, held from ISSUE through WB
//   exec_done            in   array compute complete (level or pulse)
//   ready_sig            in   sigmoid array ready
//   ready_tanh           in   tanh array ready
//   activation_function  out  AF mux select
//   tanh_in              out  tanh source select
//   wb_en                out  NORTH capture strobe, HOLD_CYCLES long
//   cmd_done             out  one-cycle pulse, command retired
//   err                  out  one-cycle pulse, illegal push (or timeout)
//   busy                 out  FSM not idle or FIFO not empty
//   fifo_count           out  occupied FIFO entries

module af_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  cmd_instr,
  input  logic [1:0]                   cmd_af,
  input  logic                         cmd_tanh_src,
  output logic                         top_start,
  output logic [31:0]                  top_instruction,
  input  logic                         exec_done,
  input  logic                         ready_sig,
  input  logic                         ready_tanh,
  output logic [1:0]                   activation_function,
  output logic                         tanh_in,
  output logic                         wb_en,
  output logic                         cmd_done,
  output logic                         err,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_EXEC, AF_WAIT, WB, DONE} state_t;

  state_t           state;
  logic [31:0]      instr_mem [CMD_DEPTH];
  logic [1:0]       af_mem    [CMD_DEPTH];
  logic             src_mem   [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       hold_cnt;
  logic             illegal;
  logic             push;
  logic             pop;
  logic             af_ready;

  assign cmd_ready = (fifo_count != CNT_W'(CMD_DEPTH));
  assign illegal   = cmd_valid && (cmd_af == 2'd3);
  assign push      = cmd_valid && cmd_ready && !illegal;
  assign pop       = (state == IDLE) && (fifo_count != '0);
  assign busy      = (state != IDLE) || (fifo_count != '0);

  // Only the ready of the array selected for this command may end AF_WAIT.
  assign af_ready  = ((activation_function == 2'd1) && ready_sig) ||
                     ((activation_function == 2'd2) && ready_tanh);

`ifdef AF_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

  // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of two.
  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset; entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= cmd_instr;
      af_mem[wr_ptr]    <= cmd_af;
      src_mem[wr_ptr]   <= cmd_tanh_src;
    end
  end

  // Command sequencer. All outputs are registered; the latched AF select doubles as the
  // command's AF code while the command is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      top_start           <= 1'b0;
      top_instruction     <= '0;
      activation_function <= '0;
      tanh_in             <= 1'b0;
      wb_en               <= 1'b0;
      cmd_done            <= 1'b0;
      err                 <= 1'b0;
      hold_cnt            <= '0;
`ifdef AF_TIMEOUT_EN
      to_cnt              <= '0;
`endif
    end else begin
      top_start <= 1'b0;
      cmd_done  <= 1'b0;
      err       <= illegal;
      case (state)
        IDLE: begin
          if (pop) begin
            top_instruction     <= instr_mem[rd_ptr];
            activation_function <= af_mem[rd_ptr];
            tanh_in             <= src_mem[rd_ptr];
            top_start           <= 1'b1;
            state               <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef AF_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= WAIT_EXEC;
        end
        WAIT_EXEC: begin
          if (exec_done) begin
            if (activation_function == 2'd0) begin
              wb_en    <= 1'b1;
              hold_cnt <= 4'(HOLD_CYCLES - 1);
              state    <= WB;
            end else begin
`ifdef AF_TIMEOUT_EN
              to_cnt <= '0;
`endif
              state <= AF_WAIT;
            end
          end
`ifdef AF_TIMEOUT_EN
          else if (to_hit) begin
            err                 <= 1'b1;
            top_instruction     <= '0;
            activation_function <= '0;
            tanh_in             <= 1'b0;
            state               <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        AF_WAIT: begin
          if (af_ready) begin
            wb_en    <= 1'b1;
            hold_cnt <= 4'(HOLD_CYCLES - 1);
            state    <= WB;
          end
`ifdef AF_TIMEOUT_EN
          else if (to_hit) begin
            err                 <= 1'b1;
            top_instruction     <= '0;
            activation_function <= '0;
            tanh_in             <= 1'b0;
            state               <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WB: begin
          if (hold_cnt == '0) begin
            wb_en               <= 1'b0;
            cmd_done            <= 1'b1;
            top_instruction     <= '0;
            activation_function <= '0;
            tanh_in             <= 1'b0;
            state               <= DONE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_af_sequencer.sv
// tb_af_sequencer
//   Self-checking bench for af_sequencer (CMD_DEPTH=4, HOLD_CYCLES=2, TIMEOUT_CYCLES=16).
//   Issued commands are compared against a queue of expected commands; single-command
//   behaviour is driven from a vector table, multi-cycle corner cases by hand.

`timescale 1ns/1ps

module tb_af_sequencer;

  localparam int CMD_DEPTH      = 4;
  localparam int HOLD_CYCLES    = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_instr = '0;
  logic [1:0]  cmd_af = '0;
  logic        cmd_tanh_src = 1'b0;
  logic        top_start;
  logic [31:0] top_instruction;
  logic        exec_done;
  logic        ready_sig;
  logic        ready_tanh;
  logic [1:0]  activation_function;
  logic        tanh_in;
  logic        wb_en;
  logic        cmd_done;
  logic        err;
  logic        busy;
  logic [2:0]  fifo_count;

  // Array-side responses come either from the automatic responder or from the test itself.
  logic manual = 1'b0;
  logic man_exec = 1'b0, man_sig = 1'b0, man_tanh = 1'b0;
  logic auto_exec = 1'b0, auto_sig = 1'b0, auto_tanh = 1'b0;

  assign exec_done  = manual ? man_exec : auto_exec;
  assign ready_sig  = manual ? man_sig  : auto_sig;
  assign ready_tanh = manual ? man_tanh : auto_tanh;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  af;
    logic        src;
  } cmd_t;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  af;
    logic        src;
    int          exec_delay;
    int          ready_delay;
    int          exp_latency;
    int          exp_wb;
  } vec_t;

  cmd_t exp_q[$];
  cmd_t obs_q[$];
  vec_t vecs[5];

  int check_cnt = 0, pass_cnt = 0;
  int cyc = 0, push_cyc = 0;
  int start_cnt = 0, done_cnt = 0, err_cnt = 0, wb_cycles = 0;
  int last_done_cyc = 0, last_err_cyc = 0;
  int sel_glitch = 0, sel_at_done = 0;
  int exec_delay = 1, ready_delay = 1;
  int exec_timer = 0, ready_timer = 0;
  logic inflight = 1'b0;
  logic [1:0] resp_af = '0;
  cmd_t at_start;

  af_sequencer #(
    .CMD_DEPTH(CMD_DEPTH), .HOLD_CYCLES(HOLD_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr), .cmd_af(cmd_af), .cmd_tanh_src(cmd_tanh_src),
    .top_start(top_start), .top_instruction(top_instruction), .exec_done(exec_done),
    .ready_sig(ready_sig), .ready_tanh(ready_tanh),
    .activation_function(activation_function), .tanh_in(tanh_in), .wb_en(wb_en),
    .cmd_done(cmd_done), .err(err), .busy(busy), .fifo_count(fifo_count)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor plus responder, on the falling edge. Observed starts go to obs_q; selects must stay
  // put from start until cmd_done, and be back at zero in the cmd_done cycle.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      inflight  = 1'b0;
      exec_timer = 0;
      ready_timer = 0;
      auto_exec = 1'b0;
      auto_sig  = 1'b0;
      auto_tanh = 1'b0;
    end else begin
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
        inflight = 1'b0;
      end
      if (top_start) begin
        obs_q.push_back('{top_instruction, activation_function, tanh_in});
        at_start = '{top_instruction, activation_function, tanh_in};
        resp_af  = activation_function;
        start_cnt++;
        inflight = 1'b1;
      end else if (inflight && !cmd_done &&
                   (top_instruction != at_start.instr || activation_function != at_start.af ||
                    tanh_in != at_start.src)) begin
        sel_glitch++;
      end
      if (wb_en) wb_cycles++;
      if (cmd_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        inflight = 1'b0;
        if (top_instruction != '0 || activation_function != '0 || tanh_in) sel_at_done++;
      end
      auto_exec = 1'b0;
      auto_sig  = 1'b0;
      auto_tanh = 1'b0;
      if (ready_timer > 0) begin
        ready_timer--;
        if (ready_timer == 0) begin
          auto_sig  = (resp_af == 2'd1);
          auto_tanh = (resp_af == 2'd2);
        end
      end
      if (top_start) begin
        exec_timer = exec_delay;
      end else if (exec_timer > 0) begin
        exec_timer--;
        if (exec_timer == 0) begin
          auto_exec = 1'b1;
          if (resp_af != 2'd0) ready_timer = ready_delay;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task tick();
    @(negedge clk);
    #1;
  endtask

  task checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Drives one push for a single cycle; commands the bench expects the DUT to accept are queued.
  task applyStimulus(input logic [31:0] instr, input logic [1:0] af, input logic src,
                     input logic expect_accept);
    cmd_valid    = 1'b1;
    cmd_instr    = instr;
    cmd_af       = af;
    cmd_tanh_src = src;
    push_cyc     = cyc;
    if (expect_accept) exp_q.push_back('{instr, af, src});
    tick();
    cmd_valid = 1'b0;
    cmd_af    = 2'd0;
  endtask

  task waitDone(input string name, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      tick();
      n++;
    end
    checkOutput(name, done_cnt, target);
  endtask

  task waitStart(input string name);
    int n;
    n = 0;
    while (!top_start && n < 50) begin
      tick();
      n++;
    end
    checkOutput(name, top_start, 1'b1);
  endtask

  task waitWb(input string name);
    int n;
    n = 0;
    while (!wb_en && n < 50) begin
      tick();
      n++;
    end
    checkOutput(name, wb_en, 1'b1);
  endtask

  task drainScoreboard();
    cmd_t e, o;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checkOutput("sb_expected_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_instr", o.instr, e.instr);
        checkOutput("sb_af", o.af, e.af);
        checkOutput("sb_src", o.src, e.src);
      end
    end
  endtask

  initial begin
    int d0, s0, e0, w0, g0, z0, p0;
    logic exp_ready [6];
    int   exp_cnt   [6];

    vecs[0] = '{32'hA5A5_0001, 2'd1, 1'b0, 4, 3, 12, 2};
    vecs[1] = '{32'h0000_1234, 2'd0, 1'b0, 1, 1,  6, 2};
    vecs[2] = '{32'hDEAD_BEEF, 2'd2, 1'b1, 2, 1,  8, 2};
    vecs[3] = '{32'h0F0F_F0F0, 2'd0, 1'b1, 3, 1,  8, 2};
    vecs[4] = '{32'h1357_9BDF, 2'd1, 1'b0, 1, 5, 11, 2};
    exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_cnt   = '{0, 1, 1, 2, 3, 4};

    // Reset held for three cycles.
    #1 reset = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outputs",
                {top_start, top_instruction, activation_function, tanh_in, wb_en, cmd_done, err, busy},
                '0);
    checkOutput("reset_cmd_ready", cmd_ready, 1'b1);
    checkOutput("reset_fifo_count", fifo_count, 3'd0);
    reset = 1'b1;
    tick();

    // Table-driven single commands with the automatic responder.
    foreach (vecs[i]) begin
      exec_delay = vecs[i].exec_delay;
      ready_delay = vecs[i].ready_delay;
      d0 = done_cnt; s0 = start_cnt; w0 = wb_cycles; g0 = sel_glitch; z0 = sel_at_done;
      applyStimulus(vecs[i].instr, vecs[i].af, vecs[i].src, 1'b1);
      waitDone("vec_done_seen", d0 + 1);
      checkOutput("vec_latency", last_done_cyc - push_cyc, vecs[i].exp_latency);
      checkOutput("vec_wb_cycles", wb_cycles - w0, vecs[i].exp_wb);
      checkOutput("vec_starts", start_cnt - s0, 1);
      checkOutput("vec_sel_stable", sel_glitch - g0, 0);
      checkOutput("vec_sel_zero_at_done", sel_at_done - z0, 0);
      tick();
      tick();
      checkOutput("vec_idle_busy", busy, 1'b0);
      drainScoreboard();
    end

    // Illegal AF code: not stored, err the following cycle.
    manual = 1'b1;
    e0 = err_cnt; s0 = start_cnt;
    applyStimulus(32'hBAD0_0003, 2'd3, 1'b0, 1'b0);
    checkOutput("illegal_err_cycle", last_err_cyc - push_cyc, 1);
    checkOutput("illegal_err_count", err_cnt - e0, 1);
    checkOutput("illegal_fifo_count", fifo_count, 3'd0);
    tick();
    tick();
    checkOutput("illegal_no_start", start_cnt - s0, 0);

    // Tanh command from NORTH; the sigmoid ready must not release AF_WAIT.
    d0 = done_cnt; w0 = wb_cycles;
    applyStimulus(32'h7A11_0002, 2'd2, 1'b1, 1'b1);
    waitStart("tanh_start_seen");
    checkOutput("tanh_in_select", tanh_in, 1'b1);
    checkOutput("tanh_af_select", activation_function, 2'd2);
    tick();
    man_exec = 1'b1;
    tick();
    man_exec = 1'b0;
    man_sig  = 1'b1;
    repeat (4) tick();
    checkOutput("tanh_ignores_ready_sig", wb_cycles - w0, 0);
    checkOutput("tanh_still_selected", activation_function, 2'd2);
    man_sig  = 1'b0;
    man_tanh = 1'b1;
    waitWb("tanh_ready_releases");
    man_tanh = 1'b0;
    waitDone("tanh_done_seen", d0 + 1);
    tick();
    drainScoreboard();

    // Fill the FIFO while the first command stalls in WAIT_EXEC; the sixth push is refused.
    d0 = done_cnt; s0 = start_cnt;
    for (int i = 0; i < 6; i++) begin
      checkOutput("fill_cmd_ready", cmd_ready, exp_ready[i]);
      checkOutput("fill_fifo_count", fifo_count, exp_cnt[i]);
      applyStimulus(32'hC0DE_0000 + i, 2'd0, i[0], exp_ready[i]);
    end
    checkOutput("full_fifo_count", fifo_count, 3'd4);
    checkOutput("full_cmd_ready", cmd_ready, 1'b0);
    man_exec = 1'b1;
    waitDone("drain_done_seen", d0 + 5);
    repeat (3) tick();
    man_exec = 1'b0;
    checkOutput("drain_done_total", done_cnt - d0, 5);
    checkOutput("drain_fifo_empty", fifo_count, 3'd0);
    checkOutput("drain_busy", busy, 1'b0);
    drainScoreboard();
    checkOutput("drain_dropped_not_issued", exp_q.size(), 0);

    // Reset during write-back with two commands queued.
    d0 = done_cnt; s0 = start_cnt; e0 = err_cnt;
    applyStimulus(32'hAB00_0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(32'hAB00_0001, 2'd0, 1'b0, 1'b1);
    applyStimulus(32'hAB00_0002, 2'd0, 1'b1, 1'b1);
    tick();
    checkOutput("rst_queued", fifo_count, 3'd2);
    man_exec = 1'b1;
    waitWb("rst_wb_reached");
    reset = 1'b0;
    #1;
    checkOutput("rst_wb_off", wb_en, 1'b0);
    checkOutput("rst_fifo_cleared", fifo_count, 3'd0);
    checkOutput("rst_instr_cleared", top_instruction, 32'h0);
    tick();
    tick();
    man_exec = 1'b0;
    reset = 1'b1;
    repeat (10) tick();
    checkOutput("rst_no_done", done_cnt - d0, 0);
    checkOutput("rst_no_err", err_cnt - e0, 0);
    checkOutput("rst_single_start", start_cnt - s0, 1);
    checkOutput("rst_busy", busy, 1'b0);
    drainScoreboard();
    checkOutput("rst_discarded", exp_q.size(), 2);
    exp_q.delete();

`ifdef AF_TIMEOUT_EN
    // Sigmoid ready never arrives: err sixteen cycles after AF_WAIT entry, then recovery.
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
    applyStimulus(32'h71E0_0001, 2'd1, 1'b0, 1'b1);
    waitStart("to_start_seen");
    tick();
    man_exec = 1'b1;
    tick();
    man_exec = 1'b0;
    p0 = cyc;
    begin
      int n;
      n = 0;
      while (err_cnt == e0 && n < 40) begin
        tick();
        n++;
      end
    end
    checkOutput("to_err_seen", err_cnt - e0, 1);
    checkOutput("to_err_cycle", last_err_cyc - p0, TIMEOUT_CYCLES);
    checkOutput("to_no_done", done_cnt - d0, 0);
    checkOutput("to_selects_cleared", activation_function, 2'd0);
    man_exec = 1'b1;
    applyStimulus(32'h71E0_0002, 2'd0, 1'b0, 1'b1);
    waitDone("to_next_done", d0 + 1);
    man_exec = 1'b0;
    checkOutput("to_next_started", start_cnt - s0, 2);
    tick();
    drainScoreboard();
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
